// File: rtl/adder_ksa_sub_pipe_pkg.sv
// ============================================================================
// Module   : adder_ksa_sub_pipe_pkg
// Purpose  : Shared sizing helpers for the pipelined Kogge-Stone subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_ksa_sub_pipe_pkg;

   localparam int ADDER_WIDTH_MIN = 2;
   localparam int ADDER_WIDTH_MAX = 64;

   function automatic int adder_levels(input int width);
      return $clog2(width);
   endfunction

   // Pipeline slots: pg register, one per prefix level, output register.
   function automatic int adder_lat(input int width);
      return $clog2(width) + 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_ksa_level.sv
// ============================================================================
// Module   : adder_ksa_level
// Purpose  : One combinational Kogge-Stone prefix level with the given span.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_ksa_level #(
   parameter int WIDTH = 16,
   parameter int SPAN  = 1
) (
   input  logic [WIDTH-1:0] i_p,
   input  logic [WIDTH-1:0] i_g,
   output logic [WIDTH-1:0] o_p,
   output logic [WIDTH-1:0] o_g
);

   for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      if (j >= SPAN) begin : g_grp
         assign o_g[j] = i_g[j] | (i_p[j] & i_g[j-SPAN]);
      end else begin : g_pass
         assign o_g[j] = i_g[j];
      end

      // Below 2*SPAN the group already reaches bit 0, so its propagate is never used again.
      if (j >= 2*SPAN) begin : g_prop
         assign o_p[j] = i_p[j] & i_p[j-SPAN];
      end else begin : g_keep
         assign o_p[j] = i_p[j];
      end
   end

endmodule

`default_nettype wire

// File: rtl/adder_ksa_sub_pipe.sv
// ============================================================================
// Module   : adder_ksa_sub_pipe
// Purpose  : Pipelined Kogge-Stone subtractor a - b - bi, valid/ready in and out.
//            Optional signed-overflow output m_ovf under macro ADDER_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_ksa_sub_pipe
   import adder_ksa_sub_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_a,
   input  logic [WIDTH-1:0] s_b,
   input  logic             s_bi,
   output logic             m_valid,
   input  logic             m_ready,
`ifdef ADDER_SUB_OVF_EN
   output logic             m_ovf,
`endif
   output logic [WIDTH:0]   m_po
);

   localparam int GP  = adder_levels(WIDTH);
   localparam int LAT = adder_lat(WIDTH);
   localparam int OUT = LAT - 1;

   logic [LAT-1:0]   r_v;
   logic [LAT-1:0]   w_adv;
   logic [LAT-1:0]   w_en;
   logic             w_go;

   logic [WIDTH-1:0] w_p0;
   logic [WIDTH-1:0] w_g0;
   logic [WIDTH-1:0] r_p  [0:GP];
   logic [WIDTH-1:0] r_g  [0:GP];
   logic [WIDTH-1:0] r_x  [0:GP];
   logic [GP:0]      r_bi;
   logic [WIDTH-1:0] w_lp [1:GP];
   logic [WIDTH-1:0] w_lg [1:GP];
   logic [WIDTH-1:0] w_d;
   logic             w_bo;
`ifdef ADDER_SUB_OVF_EN
   logic [GP:0]      r_am;
   logic [GP:0]      r_bm;
`endif

   // A slot may move when some slot above it is empty, or the output is being taken.
   always_comb begin
      w_go  = m_ready;
      w_adv = '0;
      for (int k = OUT; k >= 0; k--) begin
         w_adv[k] = r_v[k] & w_go;
         w_go     = w_go | ~r_v[k];
      end
      s_ready = w_go;
   end

   assign w_en    = {w_adv[OUT-1:0], s_valid & s_ready};
   assign m_valid = r_v[OUT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= '0;
      end else begin
         r_v <= w_en | (r_v & ~w_adv);
      end
   end

   // Subtract as a + ~b + ~bi; the carry-in is folded into g[0].
   always_comb begin
      w_p0    = s_a ^ ~s_b;
      w_g0    = s_a & ~s_b;
      w_g0[0] = w_g0[0] | (w_p0[0] & ~s_bi);
   end

   for (genvar k = 1; k <= GP; k++) begin : g_lvl
      adder_ksa_level #(
         .WIDTH (WIDTH),
         .SPAN  (1 << (k-1))
      ) u_lvl (
         .i_p (r_p[k-1]),
         .i_g (r_g[k-1]),
         .o_p (w_lp[k]),
         .o_g (w_lg[k])
      );
   end

   always_ff @(posedge clk) begin
      if (w_en[0]) begin
         r_p[0]  <= w_p0;
         r_g[0]  <= w_g0;
         r_x[0]  <= w_p0;
         r_bi[0] <= s_bi;
`ifdef ADDER_SUB_OVF_EN
         r_am[0] <= s_a[WIDTH-1];
         r_bm[0] <= s_b[WIDTH-1];
`endif
      end
      for (int k = 1; k <= GP; k++) begin
         if (w_en[k]) begin
            r_p[k]  <= w_lp[k];
            r_g[k]  <= w_lg[k];
            r_x[k]  <= r_x[k-1];
            r_bi[k] <= r_bi[k-1];
`ifdef ADDER_SUB_OVF_EN
            r_am[k] <= r_am[k-1];
            r_bm[k] <= r_bm[k-1];
`endif
         end
      end
   end

   assign w_d  = r_x[GP] ^ {r_g[GP][WIDTH-2:0], ~r_bi[GP]};
   assign w_bo = ~r_g[GP][WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_po  <= '0;
`ifdef ADDER_SUB_OVF_EN
         m_ovf <= 1'b0;
`endif
      end else if (w_en[OUT]) begin
         m_po  <= {w_bo, w_d};
`ifdef ADDER_SUB_OVF_EN
         m_ovf <= (r_am[GP] ^ r_bm[GP]) & (w_d[WIDTH-1] ^ r_am[GP]);
`endif
      end
   end

endmodule

`default_nettype wire
